aes_decryptor: RTL and testbench

AES_DECRYPTOR -- requirements
Module: aes_decryptor

---
 rtl/aes_model_pack.sv | 121 ++++++++++++
 rtl/aes_inv_round.sv | 18 +
 rtl/aes_decryptor.sv | 169 ++++++++++++++++
 tb/tb_aes_decryptor.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_model_pack.sv
// AES-128 constants, lookup tables and round helper functions shared by the decryptor.
// No ports: package only.
package aes_model_pack;

  localparam int unsigned DATA_WIDTH_IN_BYTES = 16;
  localparam int unsigned DATA_W              = DATA_WIDTH_IN_BYTES * 8;
  localparam int unsigned EMPTY_W             = $clog2(DATA_WIDTH_IN_BYTES);
  localparam int unsigned ROUNDS              = 10;
  localparam int unsigned CNT_W               = 4;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  // Inverse S-box, entry 0 in the top byte.
  localparam logic [2047:0] INV_SBOX_TAB = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  // Round constants indexed by round number 0..15 (only 1..10 are meaningful).
  localparam logic [127:0] RCON_TAB = 128'h0001020408102040801b360000000000;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TAB[2047 - 8*x -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX_TAB[2047 - 8*x -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [CNT_W-1:0] r);
    return RCON_TAB[127 - 8*r -: 8];
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  // K_r -> K_(r+1); rc is the round constant of round r+1.
  function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = rk;
    w0 = w0 ^ sub_rot_word(w3) ^ {rc, 24'h0};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // K_(r+1) -> K_r; rc is the round constant of round r+1.
  function automatic logic [127:0] inv_key_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3, w0, w1, w2, w3;
    {n0, n1, n2, n3} = rk;
    w3 = n3 ^ n2;
    w2 = n2 ^ n1;
    w1 = n1 ^ n0;
    w0 = n0 ^ sub_rot_word(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] inv_subbytes(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[8*i +: 8] = inv_sbox(x[8*i +: 8]);
    return y;
  endfunction

  // Row r of column c takes the byte from column (c - r) mod 4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] x);
    logic [127:0] y;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[127 - 8*(r + 4*c) -: 8] = x[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
    return y;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a 4-bit constant.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] p, m;
    p = '0;
    m = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) p = p ^ m;
      m = xtime(m);
    end
    return p;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] x);
    logic [127:0] y;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = x[127 - 32*c -: 8];
      a1 = x[119 - 32*c -: 8];
      a2 = x[111 - 32*c -: 8];
      a3 = x[103 - 32*c -: 8];
      y[127 - 32*c -: 8] = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
      y[119 - 32*c -: 8] = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
      y[111 - 32*c -: 8] = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
      y[103 - 32*c -: 8] = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
    end
    return y;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round.
// Ports: state (round input), round_key, last_round (skip InvMixColumns),
//        next_state_c (round output).
module aes_inv_round
  import aes_model_pack::*;
(
  input  logic [DATA_W-1:0] state,
  input  logic [DATA_W-1:0] round_key,
  input  logic              last_round,
  output logic [DATA_W-1:0] next_state_c
);

  logic [DATA_W-1:0] keyed;

  assign keyed        = inv_subbytes(inv_shift_rows(state)) ^ round_key;
  assign next_state_c = last_round ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_decryptor.sv
// AES-128 CBC decryptor, one 128-bit block per beat, 11 cycles per block.
// Ports: clk, rst (async active-low);
//        key_and_sync_* : key, sync (IV), valid in / rdy out;
//        msg_in_*       : ciphertext beat data/valid/sop/eop/empty in, rdy out;
//        msg_out_*      : plaintext beat data/valid/sop/eop/empty out, rdy in.
module aes_decryptor
  import aes_model_pack::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  key_and_sync_key,
  input  logic [DATA_W-1:0]  key_and_sync_sync,
  input  logic               key_and_sync_valid,
  output logic               key_and_sync_rdy,
  input  logic [DATA_W-1:0]  msg_in_data,
  input  logic               msg_in_valid,
  input  logic               msg_in_sop,
  input  logic               msg_in_eop,
  input  logic [EMPTY_W-1:0] msg_in_empty,
  output logic               msg_in_rdy,
  output logic [DATA_W-1:0]  msg_out_data,
  output logic               msg_out_valid,
  output logic               msg_out_sop,
  output logic               msg_out_eop,
  output logic [EMPTY_W-1:0] msg_out_empty,
  input  logic               msg_out_rdy
);

  typedef enum logic [2:0] {
    WAIT_FOR_KEY_AND_SYNC,
    KEY_EXPANSION,
    WAIT_FOR_BLOCK,
    DECRYPTION_PROCESS,
    DELIVER_BLOCK
  } fsm_state_t;

  fsm_state_t         st, st_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [DATA_W-1:0]  aes_st, aes_st_n;
  logic [DATA_W-1:0]  round_key, round_key_n;
  logic [DATA_W-1:0]  k10, k10_n;
  logic [DATA_W-1:0]  chain, chain_n;
  logic [DATA_W-1:0]  cipher, cipher_n;
  logic [DATA_W-1:0]  out_data, out_data_n;
  logic               out_sop, out_sop_n, out_eop, out_eop_n;
  logic [EMPTY_W-1:0] out_empty, out_empty_n;
  logic               key_rdy, key_rdy_n, in_rdy, in_rdy_n, out_valid, out_valid_n;
  logic [DATA_W-1:0]  dec_key, round_out;

  // Round key for the current decryption round, derived from the previous one.
  assign dec_key = inv_key_expand(round_key, rcon(cnt + CNT_W'(1)));

  aes_inv_round u_round (
    .state        (aes_st),
    .round_key    (dec_key),
    .last_round   (cnt == '0),
    .next_state_c (round_out)
  );

  // Next-state and datapath update.
  always_comb begin
    st_n        = st;
    cnt_n       = cnt;
    aes_st_n    = aes_st;
    round_key_n = round_key;
    k10_n       = k10;
    chain_n     = chain;
    cipher_n    = cipher;
    out_data_n  = out_data;
    out_sop_n   = out_sop;
    out_eop_n   = out_eop;
    out_empty_n = out_empty;
    case (st)
      WAIT_FOR_KEY_AND_SYNC: begin
        if (key_and_sync_valid && key_rdy) begin
          round_key_n = key_and_sync_key;
          chain_n     = key_and_sync_sync;
          cnt_n       = CNT_W'(1);
          st_n        = KEY_EXPANSION;
        end
      end
      KEY_EXPANSION: begin
        round_key_n = key_expand(round_key, rcon(cnt));
        cnt_n       = cnt + CNT_W'(1);
        if (cnt == CNT_W'(ROUNDS)) begin
          k10_n = round_key_n;
          cnt_n = '0;
          st_n  = WAIT_FOR_BLOCK;
        end
      end
      WAIT_FOR_BLOCK: begin
        if (msg_in_valid && in_rdy) begin
          aes_st_n    = msg_in_data ^ k10;
          cipher_n    = msg_in_data;
          out_sop_n   = msg_in_sop;
          out_eop_n   = msg_in_eop;
          out_empty_n = msg_in_empty;
          round_key_n = k10;
          cnt_n       = CNT_W'(ROUNDS - 1);
          st_n        = DECRYPTION_PROCESS;
        end
      end
      DECRYPTION_PROCESS: begin
        aes_st_n    = round_out;
        round_key_n = dec_key;
        cnt_n       = cnt - CNT_W'(1);
        if (cnt == '0) begin
          out_data_n = round_out ^ chain;
          chain_n    = cipher;
          cnt_n      = '0;
          st_n       = DELIVER_BLOCK;
        end
      end
      DELIVER_BLOCK: begin
        if (out_valid && msg_out_rdy)
          st_n = out_eop ? WAIT_FOR_KEY_AND_SYNC : WAIT_FOR_BLOCK;
      end
      default: st_n = WAIT_FOR_KEY_AND_SYNC;
    endcase
    // Handshake flags are registered copies of the upcoming state.
    key_rdy_n   = (st_n == WAIT_FOR_KEY_AND_SYNC);
    in_rdy_n    = (st_n == WAIT_FOR_BLOCK);
    out_valid_n = (st_n == DELIVER_BLOCK);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= WAIT_FOR_KEY_AND_SYNC;
      cnt       <= '0;
      aes_st    <= '0;
      round_key <= '0;
      k10       <= '0;
      chain     <= '0;
      cipher    <= '0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_empty <= '0;
      key_rdy   <= 1'b0;
      in_rdy    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      st        <= st_n;
      cnt       <= cnt_n;
      aes_st    <= aes_st_n;
      round_key <= round_key_n;
      k10       <= k10_n;
      chain     <= chain_n;
      cipher    <= cipher_n;
      out_data  <= out_data_n;
      out_sop   <= out_sop_n;
      out_eop   <= out_eop_n;
      out_empty <= out_empty_n;
      key_rdy   <= key_rdy_n;
      in_rdy    <= in_rdy_n;
      out_valid <= out_valid_n;
    end
  end

  assign key_and_sync_rdy = key_rdy;
  assign msg_in_rdy       = in_rdy;
  assign msg_out_data     = out_data;
  assign msg_out_valid    = out_valid;
  assign msg_out_sop      = out_sop;
  assign msg_out_eop      = out_eop;
  assign msg_out_empty    = out_empty;

endmodule

// File: tb/tb_aes_decryptor.sv
// Self-checking bench for aes_decryptor: known-answer vectors plus random CBC
// messages checked against a forward AES-128 model built from first principles.
module tb_aes_decryptor;

  logic         clk;
  logic         rst;
  logic [127:0] key_and_sync_key, key_and_sync_sync;
  logic         key_and_sync_valid, key_and_sync_rdy;
  logic [127:0] msg_in_data;
  logic         msg_in_valid, msg_in_sop, msg_in_eop, msg_in_rdy;
  logic [3:0]   msg_in_empty;
  logic [127:0] msg_out_data;
  logic         msg_out_valid, msg_out_sop, msg_out_eop, msg_out_rdy;
  logic [3:0]   msg_out_empty;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned key_hs = 0, in_hs = 0, out_hs = 0;
  logic [7:0] sbox_t [256];

  aes_decryptor dut (
    .clk                (clk),
    .rst                (rst),
    .key_and_sync_key   (key_and_sync_key),
    .key_and_sync_sync  (key_and_sync_sync),
    .key_and_sync_valid (key_and_sync_valid),
    .key_and_sync_rdy   (key_and_sync_rdy),
    .msg_in_data        (msg_in_data),
    .msg_in_valid       (msg_in_valid),
    .msg_in_sop         (msg_in_sop),
    .msg_in_eop         (msg_in_eop),
    .msg_in_empty       (msg_in_empty),
    .msg_in_rdy         (msg_in_rdy),
    .msg_out_data       (msg_out_data),
    .msg_out_valid      (msg_out_valid),
    .msg_out_sop        (msg_out_sop),
    .msg_out_eop        (msg_out_eop),
    .msg_out_empty      (msg_out_empty),
    .msg_out_rdy        (msg_out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake counters.
  always @(posedge clk) begin
    if (key_and_sync_valid && key_and_sync_rdy) key_hs <= key_hs + 1;
    if (msg_in_valid && msg_in_rdy)             in_hs  <= in_hs + 1;
    if (msg_out_valid && msg_out_rdy)           out_hs <= out_hs + 1;
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model: forward AES-128 ----------------
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gm(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] rk [11][16];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] out;
    for (int i = 0; i < 16; i++) rk[0][i] = key[127 - 8*i -: 8];
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      tmp[0] = sbox_t[rk[r-1][13]] ^ rc;
      tmp[1] = sbox_t[rk[r-1][14]];
      tmp[2] = sbox_t[rk[r-1][15]];
      tmp[3] = sbox_t[rk[r-1][12]];
      for (int i = 0; i < 16; i++) rk[r][i] = rk[r-1][i] ^ ((i < 4) ? tmp[i] : rk[r][i-4]);
      rc = gm(rc, 8'h02);
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rk[0][i];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[w + 4*c] = t[w + 4*((c + w) % 4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][i];
    end
    for (int i = 0; i < 16; i++) out[127 - 8*i -: 8] = s[i];
    return out;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic load_key(input logic [127:0] k, input logic [127:0] iv);
    int n;
    @(negedge clk);
    key_and_sync_key   = k;
    key_and_sync_sync  = iv;
    key_and_sync_valid = 1'b1;
    n = 0;
    while (!key_and_sync_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("key_rdy_before_accept", 128'(key_and_sync_rdy), 128'(1));
    @(negedge clk);
    key_and_sync_valid = 1'b0;
    key_and_sync_key   = rand128();
    key_and_sync_sync  = rand128();
    check_eq("key_rdy_after_accept", 128'(key_and_sync_rdy), 128'(0));
  endtask

  task automatic xfer_block(input logic [127:0] c, input logic s, input logic e,
                            input logic [3:0] emp, input logic [127:0] p, input int stall);
    int n;
    @(negedge clk);
    msg_in_data  = c;
    msg_in_sop   = s;
    msg_in_eop   = e;
    msg_in_empty = emp;
    msg_in_valid = 1'b1;
    n = 0;
    while (!msg_in_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("in_rdy_wait", 128'(msg_in_rdy), 128'(1));
    @(posedge clk);
    #1;
    msg_in_valid = 1'b0;
    msg_in_data  = rand128();
    msg_in_sop   = ~s;
    msg_in_eop   = ~e;
    msg_in_empty = ~emp;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!msg_out_valid && n < 50);
    check_eq("latency", 128'(n), 128'(10));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq("stall_data", msg_out_data, p);
      check_eq("stall_in_rdy", 128'(msg_in_rdy), 128'(0));
    end
    @(negedge clk);
    check_eq("out_valid", 128'(msg_out_valid), 128'(1));
    check_eq("out_data", msg_out_data, p);
    check_eq("out_sop", 128'(msg_out_sop), 128'(s));
    check_eq("out_eop", 128'(msg_out_eop), 128'(e));
    check_eq("out_empty", 128'(msg_out_empty), 128'(emp));
    msg_out_rdy = 1'b1;
    @(posedge clk);
    #1;
    msg_out_rdy = 1'b0;
    check_eq("valid_drop", 128'(msg_out_valid), 128'(0));
    if (e) check_eq("back_to_key", 128'(key_and_sync_rdy), 128'(1));
    else   check_eq("back_to_block", 128'(msg_in_rdy), 128'(1));
  endtask

  // ---------------- test sequence ----------------
  localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;

  logic [127:0] sp_c [4];
  logic [127:0] sp_p [4];
  logic [127:0] mk, miv, prev, pt, ct;
  logic [127:0] cq [3];
  logic [127:0] pq [3];
  int unsigned  kh0, ih0, oh0;
  int           len, n;

  initial begin
    for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
    sp_c[0] = 128'h7649abac8119b246cee98e9b12e9197d;
    sp_c[1] = 128'h5086cb9b507219ee95db113a917678b2;
    sp_c[2] = 128'h73bed6b8e3c1743b7116e69e22229516;
    sp_c[3] = 128'h3ff1caa1681fac09120eca307586e1a7;
    sp_p[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
    sp_p[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    sp_p[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    sp_p[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;

    rst = 1'b1;
    key_and_sync_key = '0; key_and_sync_sync = '0; key_and_sync_valid = 1'b0;
    msg_in_data = '0; msg_in_valid = 1'b0; msg_in_sop = 1'b0; msg_in_eop = 1'b0;
    msg_in_empty = '0; msg_out_rdy = 1'b0;
    #2 rst = 1'b0;

    // Reset values.
    @(negedge clk);
    check_eq("rst_out_valid", 128'(msg_out_valid), 128'(0));
    check_eq("rst_out_data", msg_out_data, 128'(0));
    check_eq("rst_flags", 128'({msg_out_sop, msg_out_eop, msg_out_empty}), 128'(0));
    check_eq("rst_in_rdy", 128'(msg_in_rdy), 128'(0));
    check_eq("rst_key_rdy", 128'(key_and_sync_rdy), 128'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("key_rdy_first_edge", 128'(key_and_sync_rdy), 128'(1));

    // FIPS-197 C.1 single block.
    load_key(FIPS_K, 128'h0);
    xfer_block(FIPS_C, 1'b1, 1'b1, 4'h0, FIPS_P, 0);

    // SP800-38A F.2.2 CBC, with 20 cycles of backpressure on the second block.
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h000102030405060708090a0b0c0d0e0f);
    for (int i = 0; i < 4; i++)
      xfer_block(sp_c[i], i == 0, i == 3, 4'h0, sp_p[i], (i == 1) ? 20 : 0);
    check_eq("sp_in_rdy_idle", 128'(msg_in_rdy), 128'(0));

    // Reset while the counter is at 5 of the decryption rounds.
    load_key(FIPS_K, 128'h0);
    @(negedge clk);
    msg_in_data = FIPS_C; msg_in_sop = 1'b1; msg_in_eop = 1'b1; msg_in_empty = 4'h7;
    msg_in_valid = 1'b1;
    n = 0;
    while (!msg_in_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_test_in_rdy", 128'(msg_in_rdy), 128'(1));
    @(posedge clk);
    #1;
    msg_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_eq("midrst_valid", 128'(msg_out_valid), 128'(0));
    check_eq("midrst_data", msg_out_data, 128'(0));
    check_eq("midrst_flags", 128'({msg_out_sop, msg_out_eop, msg_out_empty}), 128'(0));
    check_eq("midrst_rdys", 128'({msg_in_rdy, key_and_sync_rdy}), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    load_key(FIPS_K, 128'h0);
    xfer_block(FIPS_C, 1'b1, 1'b1, 4'h0, FIPS_P, 0);

    // Valid inputs held high throughout a 3-block message.
    mk = rand128();
    miv = rand128();
    prev = miv;
    for (int i = 0; i < 3; i++) begin
      pq[i] = rand128();
      cq[i] = aes_enc(pq[i] ^ prev, mk);
      prev  = cq[i];
    end
    kh0 = key_hs; ih0 = in_hs; oh0 = out_hs;
    @(negedge clk);
    key_and_sync_key = mk; key_and_sync_sync = miv; key_and_sync_valid = 1'b1;
    msg_in_valid = 1'b1; msg_in_empty = 4'h0; msg_out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      msg_in_data = cq[i];
      msg_in_sop  = (i == 0);
      msg_in_eop  = (i == 2);
      n = 0;
      while (!msg_out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      check_eq("cont_valid", 128'(msg_out_valid), 128'(1));
      check_eq("cont_data", msg_out_data, pq[i]);
      if (i == 2) begin
        key_and_sync_valid = 1'b0;
        msg_in_valid = 1'b0;
      end
      @(negedge clk);
    end
    msg_out_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("cont_key_hs", 128'(key_hs - kh0), 128'(1));
    check_eq("cont_in_hs", 128'(in_hs - ih0), 128'(3));
    check_eq("cont_out_hs", 128'(out_hs - oh0), 128'(3));

    // Random CBC messages against the model.
    for (int m = 0; m < 4; m++) begin
      mk = rand128();
      miv = rand128();
      len = int'($urandom_range(1, 4));
      load_key(mk, miv);
      prev = miv;
      for (int b = 0; b < len; b++) begin
        pt = rand128();
        ct = aes_enc(pt ^ prev, mk);
        prev = ct;
        xfer_block(ct, b == 0, b == len - 1, 4'($urandom_range(0, 15)), pt,
                   int'($urandom_range(0, 3)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
